// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR snapshot read path:
//   - csr_rd_state_t : read FSM state encoding
//   - CSR_BUS_WIDTH  : default CSR read data width
//   - clog2_min1     : ceil(log2(n)), never less than 1 (sizes the word index)
// -----------------------------------------------------------------------------
package csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } csr_rd_state_t;

  localparam int CSR_BUS_WIDTH = 32;

  // ceil(log2(n)) with a floor of 1 so a single-word value still gets a 1-bit index
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/csr_snapshot_read.sv
// -----------------------------------------------------------------------------
// csr_snapshot_read
// Serves a wide live status value to the CSR read mux as a series of
// BUS_WIDTH words. Reading word 0 captures a coherent snapshot of the whole
// value; higher words are served from that snapshot so a multi-word read of
// a running counter never tears.
//
// Ports (single clock domain cclk, synchronous active-high reset):
//   cclk               in   clock
//   rst_cclk           in   reset; drops any in-flight read without an ack
//   status_cclk        in   [WIDTH]     live status value
//   status_valid_cclk  in   status_cclk is coherent this cycle
//   rd_strobe_cclk     in   single-cycle read request (ignored unless idle)
//   rd_word_cclk       in   [WIDX]      word index, sampled with the strobe
//   rd_wait_cclk       out  read in progress
//   rd_ack_cclk        out  one-cycle response pulse
//   rd_data_cclk       out  [BUS_WIDTH] response data, held until next ack
//   rd_err_cclk        out  error qualifier, valid with rd_ack_cclk
//
// Build option:
//   CSR_RD_TIMEOUT_EN  when defined, CAPTURE gives up after TIMEOUT cycles
//                      without status_valid_cclk and answers with an error.
//                      When undefined, CAPTURE waits indefinitely.
// -----------------------------------------------------------------------------
module csr_snapshot_read
  import csr_pkg::*;
#(
  parameter int  WIDTH       = 64,
  parameter int  BUS_WIDTH   = CSR_BUS_WIDTH,
  parameter int  WAIT_CYCLES = 0,
  parameter int  TIMEOUT     = 1023,
  localparam int NWORDS      = WIDTH / BUS_WIDTH,
  localparam int WIDX        = clog2_min1(NWORDS)
) (
  input  logic                 cclk,
  input  logic                 rst_cclk,
  input  logic [WIDTH-1:0]     status_cclk,
  input  logic                 status_valid_cclk,
  input  logic                 rd_strobe_cclk,
  input  logic [WIDX-1:0]      rd_word_cclk,
  output logic                 rd_wait_cclk,
  output logic                 rd_ack_cclk,
  output logic [BUS_WIDTH-1:0] rd_data_cclk,
  output logic                 rd_err_cclk
);

  localparam logic [7:0]    WAIT_INIT = 8'(WAIT_CYCLES);
  localparam logic [WIDX:0] NWORDS_L  = (WIDX + 1)'(NWORDS);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  csr_rd_state_t         r_state;
  logic [WIDX-1:0]       r_widx;
  logic [7:0]            r_wait_cnt;
  logic [WIDTH-1:0]      r_snap;
  logic                  r_ack;
  logic                  r_wait;
  logic [BUS_WIDTH-1:0]  r_data;
  logic                  r_err;

  csr_rd_state_t         w_state_nxt;
  logic [WIDX-1:0]       w_widx_nxt;
  logic [7:0]            w_wait_cnt_nxt;
  logic [WIDTH-1:0]      w_snap_nxt;
  logic                  w_timeout;
  logic                  w_in_range;
  logic [BUS_WIDTH-1:0]  w_word;
  logic                  w_ack_nxt;
  logic                  w_wait_nxt;
  logic [BUS_WIDTH-1:0]  w_data_nxt;
  logic                  w_err_nxt;

`ifdef CSR_RD_TIMEOUT_EN
  localparam int            TO_W    = clog2_min1(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0]          r_to_cnt;
  logic [TO_W-1:0]          w_to_cnt_nxt;
`else
  // TIMEOUT has no function when the capture timeout is compiled out
  logic                     w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // State register plus all registered datapath and outputs
  always_ff @(posedge cclk) begin
    if (rst_cclk) begin
      r_state    <= ST_IDLE;
      r_widx     <= {WIDX{1'b0}};
      r_wait_cnt <= 8'd0;
      r_snap     <= {WIDTH{1'b0}};
      r_ack      <= 1'b0;
      r_wait     <= 1'b0;
      r_data     <= {BUS_WIDTH{1'b0}};
      r_err      <= 1'b0;
`ifdef CSR_RD_TIMEOUT_EN
      r_to_cnt   <= {TO_W{1'b0}};
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_widx     <= w_widx_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_snap     <= w_snap_nxt;
      r_ack      <= w_ack_nxt;
      r_wait     <= w_wait_nxt;
      r_data     <= w_data_nxt;
      r_err      <= w_err_nxt;
`ifdef CSR_RD_TIMEOUT_EN
      r_to_cnt   <= w_to_cnt_nxt;
`endif
    end
  end

  // Next-state and datapath update logic
  // The CAPTURE cycle that takes the snapshot also consumes one wait slot, so
  // word 0 and word n both answer WAIT_CYCLES+2 cycles after the strobe when
  // status is valid straight away.
  always_comb begin
    w_state_nxt    = r_state;
    w_widx_nxt     = r_widx;
    w_wait_cnt_nxt = r_wait_cnt;
    w_snap_nxt     = r_snap;
    w_timeout      = 1'b0;
`ifdef CSR_RD_TIMEOUT_EN
    w_to_cnt_nxt   = r_to_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (rd_strobe_cclk) begin
          w_widx_nxt     = rd_word_cclk;
          w_wait_cnt_nxt = WAIT_INIT;
`ifdef CSR_RD_TIMEOUT_EN
          w_to_cnt_nxt   = {TO_W{1'b0}};
`endif
          if (rd_word_cclk == {WIDX{1'b0}}) begin
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (status_valid_cclk) begin
          w_snap_nxt = status_cclk;
          if (r_wait_cnt == 8'd0) begin
            w_state_nxt = ST_RESPOND;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - 8'd1;
            w_state_nxt    = ST_WAIT;
          end
        end else begin
`ifdef CSR_RD_TIMEOUT_EN
          if (r_to_cnt == TO_LAST) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_RESPOND;
          end else begin
            w_to_cnt_nxt = r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
            w_state_nxt  = ST_CAPTURE;
          end
`else
          w_state_nxt = ST_CAPTURE;
`endif
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 8'd0) begin
          w_state_nxt = ST_RESPOND;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 8'd1;
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_RESPOND: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word-select mux over the snapshot as it will stand after this cycle, so a
  // capture that goes straight to RESPOND returns the freshly captured word
  always_comb begin
    w_in_range = ({1'b0, r_widx} < NWORDS_L);
    w_word     = {BUS_WIDTH{1'b0}};
    for (int i = 0; i < NWORDS; i++) begin
      w_word = (r_widx == i[WIDX-1:0]) ? w_snap_nxt[i*BUS_WIDTH +: BUS_WIDTH] : w_word;
    end
  end

  // Output logic: values registered for the cycle the FSM is entering
  always_comb begin
    w_ack_nxt  = (w_state_nxt == ST_RESPOND);
    w_wait_nxt = (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_WAIT);
    w_err_nxt  = 1'b0;
    w_data_nxt = r_data;
    if (w_ack_nxt) begin
      if (w_timeout || !w_in_range) begin
        w_err_nxt  = 1'b1;
        w_data_nxt = {BUS_WIDTH{1'b0}};
      end else begin
        w_err_nxt  = 1'b0;
        w_data_nxt = w_word;
      end
    end else begin
      w_err_nxt  = 1'b0;
      w_data_nxt = r_data;
    end
  end

  assign rd_ack_cclk  = r_ack;
  assign rd_wait_cclk = r_wait;
  assign rd_data_cclk = r_data;
  assign rd_err_cclk  = r_err;

endmodule
